// File: rtl/disp_scheduler.sv
// disp_scheduler
// Two-channel binary-to-7-segment display controller built around one
// sequential double-dabble converter that serves channels A and B in strict
// round-robin. Each channel keeps a registered four-digit pattern
// (sign, hundreds, tens, units). Patterns are active-high.
//
// Parameters:
//   SIGNED  1: inputs are two's complement (-128..127); 0: unsigned (0..255)
//   HOLD    idle cycles inserted after each channel write (0..255)
//
// Ports:
//   clk     rising-edge clock
//   nreset  synchronous active-low reset
//   a_in    channel A value
//   b_in    channel B value
//   a_disp  channel A patterns: [0] units, [1] tens, [2] hundreds, [3] sign
//   b_disp  channel B patterns, same layout
//   a_upd   one-cycle pulse when a_disp first shows a new result
//   b_upd   one-cycle pulse when b_disp first shows a new result
//   busy    high in LOAD, SHIFT and WRITE; low in WAIT
//   chan    channel owning the converter (0 = A, 1 = B)
module disp_scheduler #(
  parameter int SIGNED = 1,
  parameter int HOLD   = 0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [7:0]      a_in,
  input  logic [7:0]      b_in,
  output logic [3:0][6:0] a_disp,
  output logic [3:0][6:0] b_disp,
  output logic            a_upd,
  output logic            b_upd,
  output logic            busy,
  output logic            chan
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Last value of the hold counter before returning to LOAD. Only used when
  // HOLD > 0, so the wrap for HOLD = 0 is harmless.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t      state;
  logic [7:0]  mag;
  logic [11:0] bcd;
  logic        neg;
  logic [7:0]  bit_cnt;
  logic [7:0]  hold_cnt;

  logic [7:0]      sel_in;
  logic            sel_neg;
  logic [11:0]     bcd_adj;
  logic [3:0][6:0] enc;

  assign sel_in  = chan ? b_in : a_in;
  assign sel_neg = (SIGNED != 0) && sel_in[7];

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ?
                                  (bcd[gi*4 +: 4] + 4'd3) : bcd[gi*4 +: 4];
    end
  endgenerate

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;  // unreachable codes show blank
    endcase
    return s;
  endfunction

  // Encoded result with leading-zero blanking; the units digit always shows.
  always_comb begin
    enc    = '0;
    enc[0] = seg(bcd[3:0]);
    if (bcd[11:8] != 4'd0 || bcd[7:4] != 4'd0)
      enc[1] = seg(bcd[7:4]);
    if (bcd[11:8] != 4'd0)
      enc[2] = seg(bcd[11:8]);
    enc[3] = neg ? 7'h40 : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= LOAD;
      chan     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      neg      <= 1'b0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      a_disp   <= '0;
      b_disp   <= '0;
      a_upd    <= 1'b0;
      b_upd    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      a_upd <= 1'b0;
      b_upd <= 1'b0;
      case (state)
        LOAD: begin
          // Only sample point for the selected channel.
          neg     <= sel_neg;
          mag     <= sel_neg ? (~sel_in + 8'd1) : sel_in;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
          busy    <= 1'b1;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          bit_cnt    <= bit_cnt + 8'd1;
          if (bit_cnt == 8'd7)
            state <= WRITE;
          busy <= 1'b1;
        end
        WRITE: begin
          if (chan) begin
            b_disp <= enc;
            b_upd  <= 1'b1;
          end else begin
            a_disp <= enc;
            a_upd  <= 1'b1;
          end
          chan     <= ~chan;
          hold_cnt <= '0;
          if (HOLD == 0) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            state <= WAIT;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        default: begin
          state <= LOAD;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Testbench for disp_scheduler: table-driven conversions on a signed and an
// unsigned instance plus hand-written reset, input-stability, mid-conversion
// reset and HOLD=3 sequences.
module tb_disp_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Signed, HOLD=0
  logic            nrst_s;
  logic [7:0]      a_s, b_s;
  logic [3:0][6:0] ad_s, bd_s;
  logic            au_s, bu_s, busy_s, chan_s;
  // Unsigned, HOLD=0
  logic            nrst_u;
  logic [7:0]      a_u, b_u;
  logic [3:0][6:0] ad_u, bd_u;
  logic            au_u, bu_u, busy_u, chan_u;
  // Signed, HOLD=3
  logic            nrst_h;
  logic [7:0]      a_h, b_h;
  logic [3:0][6:0] ad_h, bd_h;
  logic            au_h, bu_h, busy_h, chan_h;

  disp_scheduler #(.SIGNED(1), .HOLD(0)) dut_s (
    .clk(clk), .nreset(nrst_s), .a_in(a_s), .b_in(b_s),
    .a_disp(ad_s), .b_disp(bd_s), .a_upd(au_s), .b_upd(bu_s),
    .busy(busy_s), .chan(chan_s));

  disp_scheduler #(.SIGNED(0), .HOLD(0)) dut_u (
    .clk(clk), .nreset(nrst_u), .a_in(a_u), .b_in(b_u),
    .a_disp(ad_u), .b_disp(bd_u), .a_upd(au_u), .b_upd(bu_u),
    .busy(busy_u), .chan(chan_u));

  disp_scheduler #(.SIGNED(1), .HOLD(3)) dut_h (
    .clk(clk), .nreset(nrst_h), .a_in(a_h), .b_in(b_h),
    .a_disp(ad_h), .b_disp(bd_h), .a_upd(au_h), .b_upd(bu_h),
    .busy(busy_h), .chan(chan_h));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          uns;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [27:0] ea;  // {sign, hundreds, tens, units}
    logic [27:0] eb;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    nrst_s = 1'b0; nrst_u = 1'b0; nrst_h = 1'b0;
    a_s = '0; b_s = '0; a_u = '0; b_u = '0; a_h = '0; b_h = '0;

    vecs[0] = '{1'b0, 8'h7B, 8'hF6, {7'h00, 7'h06, 7'h5B, 7'h4F}, {7'h40, 7'h00, 7'h06, 7'h3F}};
    vecs[1] = '{1'b0, 8'h80, 8'h00, {7'h40, 7'h06, 7'h5B, 7'h7F}, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[2] = '{1'b1, 8'hFF, 8'h80, {7'h00, 7'h5B, 7'h6D, 7'h6D}, {7'h00, 7'h06, 7'h5B, 7'h7F}};
    vecs[3] = '{1'b0, 8'hFF, 8'h7F, {7'h40, 7'h00, 7'h00, 7'h06}, {7'h00, 7'h06, 7'h5B, 7'h07}};
    vecs[4] = '{1'b1, 8'h0A, 8'h64, {7'h00, 7'h00, 7'h06, 7'h3F}, {7'h00, 7'h06, 7'h3F, 7'h3F}};
    vecs[5] = '{1'b0, 8'h9C, 8'hF6, {7'h40, 7'h06, 7'h3F, 7'h3F}, {7'h40, 7'h00, 7'h06, 7'h3F}};

    // ---- Reset behaviour and upd timing (signed, HOLD=0) ----
    a_s = 8'h7B;
    repeat (3) tick();
    chk("rst a_disp", ad_s, 28'h0);
    chk("rst b_disp", bd_s, 28'h0);
    chk("rst upd", {26'h0, au_s, bu_s}, 28'h0);
    chk("rst busy", {27'h0, busy_s}, 28'h0);
    chk("rst chan", {27'h0, chan_s}, 28'h0);
    nrst_s = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (au_s !== (k == 10 || k == 30) || bu_s !== (k == 20) || busy_s !== 1'b1) begin
        chk($sformatf("upd/busy edge %0d", k), {25'h0, au_s, bu_s, busy_s},
            {25'h0, 1'(k == 10 || k == 30), 1'(k == 20), 1'b1});
      end else begin
        n_cmp++;
      end
    end
    chk("a_disp 123", ad_s, {7'h00, 7'h06, 7'h5B, 7'h4F});

    // ---- Table-driven conversions ----
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].uns) begin
        nrst_u = 1'b0; a_u = vecs[i].a; b_u = vecs[i].b;
      end else begin
        nrst_s = 1'b0; a_s = vecs[i].a; b_s = vecs[i].b;
      end
      repeat (2) tick();
      nrst_s = 1'b1; nrst_u = 1'b1;
      repeat (10) tick();
      chk($sformatf("vec%0d a_disp", i), vecs[i].uns ? ad_u : ad_s, vecs[i].ea);
      chk($sformatf("vec%0d a_upd", i), {27'h0, vecs[i].uns ? au_u : au_s}, 28'h1);
      repeat (10) tick();
      chk($sformatf("vec%0d b_disp", i), vecs[i].uns ? bd_u : bd_s, vecs[i].eb);
      chk($sformatf("vec%0d b_upd", i), {27'h0, vecs[i].uns ? bu_u : bu_s}, 28'h1);
    end

    // ---- Input stability: change a_in mid-conversion ----
    nrst_s = 1'b0; a_s = 8'h05; b_s = 8'h00;
    repeat (2) tick();
    nrst_s = 1'b1;
    repeat (4) tick();
    a_s = 8'h63;
    repeat (6) tick();
    chk("stab first write", ad_s, {7'h00, 7'h00, 7'h00, 7'h6D});
    repeat (20) tick();
    chk("stab second write", ad_s, {7'h00, 7'h00, 7'h6F, 7'h6F});

    // ---- Reset in the middle of a B conversion ----
    nrst_s = 1'b0; a_s = 8'h7B; b_s = 8'hF6;
    repeat (2) tick();
    nrst_s = 1'b1;
    repeat (15) tick();
    chk("mid a_disp before", ad_s, {7'h00, 7'h06, 7'h5B, 7'h4F});
    nrst_s = 1'b0;
    tick();
    chk("mid a_disp cleared", ad_s, 28'h0);
    chk("mid b_disp cleared", bd_s, 28'h0);
    nrst_s = 1'b1;
    repeat (9) tick();
    chk("mid a_disp edge9", ad_s, 28'h0);
    tick();
    chk("mid a_disp rewritten", ad_s, {7'h00, 7'h06, 7'h5B, 7'h4F});
    repeat (9) tick();
    chk("mid b_disp edge19", bd_s, 28'h0);
    tick();
    chk("mid b_disp edge20", bd_s, {7'h40, 7'h00, 7'h06, 7'h3F});

    // ---- HOLD=3: upd spacing and busy gaps ----
    a_h = 8'h2A; b_h = 8'h80;
    nrst_h = 1'b0;
    repeat (2) tick();
    nrst_h = 1'b1;
    chk("hold busy pre", {27'h0, busy_h}, 28'h0);
    for (int k = 1; k <= 40; k++) begin
      logic ea, eb, ebusy;
      tick();
      ea    = (k == 10 || k == 36);
      eb    = (k == 23);
      ebusy = !((k >= 10 && k <= 12) || (k >= 23 && k <= 25) || (k >= 36 && k <= 38));
      if (au_h !== ea || bu_h !== eb || busy_h !== ebusy) begin
        chk($sformatf("hold edge %0d", k), {25'h0, au_h, bu_h, busy_h},
            {25'h0, ea, eb, ebusy});
      end else begin
        n_cmp++;
      end
    end
    chk("hold a_disp 42", ad_h, {7'h00, 7'h00, 7'h66, 7'h5B});
    chk("hold b_disp -128", bd_h, {7'h40, 7'h06, 7'h5B, 7'h7F});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Never both upd pulses together on any instance.
  always @(negedge clk) begin
    if ((au_s && bu_s) || (au_u && bu_u) || (au_h && bu_h)) begin
      n_cmp++;
      n_err++;
      $display("FAIL upd overlap: a_upd and b_upd both high, required exclusive");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Time-shared signed binary-to-7-segment display controller for the DE0 demo top level. It serves two 8-bit channels (A: switch value, B: LED/result value) with one sequential double-dabble converter, in strict round-robin. Each channel gets a registered four-digit pattern: sign, hundreds, tens and units. Patterns are active-high, and the top level inverts them for the HEX outputs.

## Interface
Parameters:
- SIGNED, default 1: 1 treats inputs as two's complement (-128..127); 0 treats them as unsigned (0..255).
- HOLD, default 0: idle cycles inserted after each channel write (0..255). Use it to throttle the refresh rate.

Ports:
- clk  in  1: single clock; all logic is on the rising edge.
- nreset  in  1: reset, synchronous, active-low.
- a_in  in  8: channel A value.
- b_in  in  8: channel B value.
- a_disp  out  4×7: channel A patterns. [0] units, [1] tens, [2] hundreds, [3] sign.
- b_disp  out  4×7: channel B patterns, same layout as a_disp.
- a_upd  out  1: one-cycle pulse, high in the cycle a_disp first shows a new result.
- b_upd  out  1: one-cycle pulse, high in the cycle b_disp first shows a new result.
- busy  out  1: high in LOAD, SHIFT and WRITE; low in WAIT.
- chan  out  1: channel currently owning the converter (0 = A, 1 = B).

## Operation
- State machine: LOAD → SHIFT (8 cycles) → WRITE → WAIT (HOLD cycles; skipped when HOLD=0) → LOAD.
- LOAD (1 cycle):
  - Sample the selected input; this is the only sample point, and input changes at any other time are ignored until the next LOAD of that channel.
  - neg = SIGNED & in[7].
  - mag = neg ? (~in + 1) : in, 8-bit unsigned; -128 gives 128.
  - Clear the 12-bit BCD register; bit counter = 0.
- SHIFT (8 cycles):
  - Each cycle, add 3 to every BCD nibble ≥ 5.
  - Then shift {bcd, mag} left by one.
  - Leave after the counter reaches 7.
- WRITE (1 cycle):
  - Encode the nibbles and load the selected channel's disp register.
  - Pulse that channel's upd.
  - Toggle chan.
  - The other channel's disp register holds its value.
- Segment encoding, bit0 = a … bit6 = g, active-high:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66.
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- Leading-zero blanking:
  - Hundreds digit = 00 when the hundreds nibble is 0.
  - Tens digit = 00 when both the hundreds and tens nibbles are 0.
  - Units digit is always shown.
- Sign digit: 40 (segment g only) when neg, else 00. It is always 00 when SIGNED=0.
- Nibble values > 9 cannot occur. If one does, the encoder outputs 00 (blank).

## Timing
- Reset (nreset low at a rising edge):
  - state = LOAD, chan = 0.
  - a_disp and b_disp all 00 (blank).
  - a_upd = b_upd = 0, busy = 0.
  - Internal counters 0.
- Reset mid-conversion abandons the conversion without writing; the next conversion restarts on channel A.
- Cycle numbering: edge 1 is the first rising edge with nreset high.
  - Edge 1: LOAD A.
  - Edges 2–9: SHIFT.
  - Edge 10: WRITE A. a_disp updates and a_upd is high for the following cycle.
- Per-channel latency is 10 cycles from the sample edge to the display update.
- Round-robin period is 2×(10 + HOLD) cycles.
  - With HOLD=0, B is written at edge 20 and A again at edge 30.
- a_upd and b_upd are never high in the same cycle; each pulse is exactly 1 cycle wide.
- busy is registered and matches the state for the current cycle.
  - busy = 0 after reset until the first LOAD edge.
  - busy = 0 throughout WAIT.
- Internal bit and hold counters are 8 bits wide; HOLD=255 must not wrap early.

## Test plan
- Reset: hold nreset low 3 cycles with a_in=7B → all disp = 00, upd = 0. After release: a_upd at edge 10, b_upd at edge 20, a_upd again at edge 30 (HOLD=0).
- Signed values, SIGNED=1, a_in=7B (123), b_in=F6 (-10):
  - a_disp[3..0] = 00,06,5B,4F.
  - b_disp[3..0] = 40,00,06,3F.
- Boundary values:
  - SIGNED=1, a_in=80 → a_disp 40,06,5B,7F (-128).
  - SIGNED=1, a_in=00 → a_disp 00,00,00,3F.
  - SIGNED=0, a_in=FF → a_disp 00,5B,6D,6D.
  - SIGNED=0, a_in=80 → a_disp 00,06,5B,7F.
- Input stability: a_in=05 at LOAD, changed to 63 at edge 5 → that write shows 00,00,00,6D. The next A write shows 00,00,6F,6F (99).
- Reset mid-operation: with a_disp already showing 123, assert nreset low at edge 6 of a B conversion → b_disp and a_disp both 00 immediately. A is rewritten at edge 10 after release; b_disp holds 00 until edge 20.
- HOLD=3: successive upd pulses 13 cycles apart (A at 10, B at 23, A at 36); busy low for exactly 3 cycles after each WRITE.
